// File: rtl/word_comparator.sv
// rtl/word_comparator.sv - equality/magnitude comparator with combinational eq and registered flag bundle
// Optional COMPARATOR_MASK_EN adds a per-bit ignore mask applied to both operands.
module word_comparator #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
`ifdef COMPARATOR_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic             eq,
    output logic             out_valid,
    output logic             eq_q,
    output logic             lt_u,
    output logic             gt_u,
    output logic             lt_s,
    output logic             gt_s,
    output logic [IDX_W-1:0] diff_idx
);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] diff;
    logic             lt_u_c;
    logic             gt_u_c;
    logic             lt_s_c;
    logic             gt_s_c;
    logic [IDX_W-1:0] idx_c;

`ifdef COMPARATOR_MASK_EN
    assign op_a = a & ~mask;
    assign op_b = b & ~mask;
`else
    assign op_a = a;
    assign op_b = b;
`endif

    assign diff   = op_a ^ op_b;
    assign eq     = (diff == '0);
    assign lt_u_c = (op_a < op_b);
    assign gt_u_c = (op_a > op_b);

    // Differing sign bits decide the signed order outright; the negative operand is smaller.
    assign lt_s_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) ? op_a[WIDTH-1] : lt_u_c;
    assign gt_s_c = (op_a[WIDTH-1] != op_b[WIDTH-1]) ? op_b[WIDTH-1] : gt_u_c;

    // Ascending scan so the highest set bit wins.
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (diff[i]) begin
                idx_c = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            eq_q      <= 1'b0;
            lt_u      <= 1'b0;
            gt_u      <= 1'b0;
            lt_s      <= 1'b0;
            gt_s      <= 1'b0;
            diff_idx  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                eq_q     <= eq;
                lt_u     <= lt_u_c;
                gt_u     <= gt_u_c;
                lt_s     <= lt_s_c;
                gt_s     <= gt_s_c;
                diff_idx <= idx_c;
            end
        end
    end

endmodule

// File: tb/tb_word_comparator.sv
// tb/tb_word_comparator.sv - directed self-checking bench for word_comparator
module tb_word_comparator;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
`ifdef COMPARATOR_MASK_EN
    logic [31:0] mask;
`endif
    logic        eq;
    logic        out_valid;
    logic        eq_q;
    logic        lt_u;
    logic        gt_u;
    logic        lt_s;
    logic        gt_s;
    logic [5:0]  diff_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    word_comparator #(.WIDTH(32), .IDX_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
`ifdef COMPARATOR_MASK_EN
        .mask      (mask),
`endif
        .eq        (eq),
        .out_valid (out_valid),
        .eq_q      (eq_q),
        .lt_u      (lt_u),
        .gt_u      (gt_u),
        .lt_s      (lt_s),
        .gt_s      (gt_s),
        .diff_idx  (diff_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Registered bundle packed as {out_valid, eq_q, lt_u, gt_u, lt_s, gt_s, diff_idx}.
    task automatic check_reg(input string tag, input logic ov, input logic e, input logic lu,
                             input logic gu, input logic ls, input logic gs, input logic [5:0] idx);
        check(tag, {20'd0, out_valid, eq_q, lt_u, gt_u, lt_s, gt_s, diff_idx},
                   {20'd0, ov, e, lu, gu, ls, gs, idx});
    endtask

    task automatic drive(input logic [31:0] va, input logic [31:0] vb, input logic v);
        a = va;
        b = vb;
        in_valid = v;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b0);
`ifdef COMPARATOR_MASK_EN
        mask = 32'h0;
`endif
        tick();
        tick();
        check_reg("reset_state", 0, 0, 0, 0, 0, 0, 6'd0);
        reset = 1'b0;

        drive(32'h00000000, 32'h00000000, 1'b1);
        #1 check("eq_zero", eq, 1);
        tick();
        check_reg("reg_zero", 1, 1, 0, 0, 0, 0, 6'd0);

        drive(32'h00008000, 32'h00000000, 1'b1);
        #1 check("eq_8000", eq, 0);
        tick();
        check_reg("reg_8000", 1, 0, 0, 1, 0, 1, 6'd15);

        drive(32'haaaaaaaa, 32'haaaaaaaa, 1'b1);
        #1 check("eq_aaaa", eq, 1);
        tick();
        check_reg("reg_aaaa", 1, 1, 0, 0, 0, 0, 6'd0);
        drive(32'hf0000000, 32'he0000000, 1'b1);
        #1 check("eq_f0e0", eq, 0);
        tick();
        check_reg("reg_f0e0", 1, 0, 0, 1, 0, 1, 6'd28);

        drive(32'h80000000, 32'h00000001, 1'b1);
        tick();
        check_reg("reg_sign_split", 1, 0, 0, 1, 1, 0, 6'd31);

        drive(32'h11111111, 32'h11111110, 1'b1);
        tick();
        check_reg("reg_bit0", 1, 0, 0, 1, 0, 1, 6'd0);

        drive(32'h00000000, 32'hffffffff, 1'b1);
        tick();
        check_reg("reg_zero_vs_neg1", 1, 0, 1, 0, 0, 1, 6'd31);

        drive(32'hfffffffe, 32'hffffffff, 1'b1);
        tick();
        check_reg("reg_both_neg", 1, 0, 1, 0, 1, 0, 6'd0);

        drive(32'h00000001, 32'h00000002, 1'b1);
        tick();
        check_reg("reg_1_vs_2", 1, 0, 1, 0, 1, 0, 6'd1);

        // Idle cycle: only out_valid drops, flags keep the 1-vs-2 result.
        drive(32'h12345678, 32'h12345678, 1'b0);
        #1 check("eq_idle", eq, 1);
        tick();
        check_reg("reg_hold", 0, 0, 1, 0, 1, 0, 6'd1);

        drive(32'h00000005, 32'h00000003, 1'b1);
        reset = 1'b1;
        #1 check("eq_during_reset", eq, 0);
        tick();
        check_reg("reg_reset_priority", 0, 0, 0, 0, 0, 0, 6'd0);
        drive(32'h00000005, 32'h00000005, 1'b1);
        #1 check("eq_tracks_in_reset", eq, 1);
        reset = 1'b0;
        tick();
        check_reg("reg_after_reset", 1, 1, 0, 0, 0, 0, 6'd0);

`ifdef COMPARATOR_MASK_EN
        mask = 32'h00000001;
        drive(32'h11111111, 32'h11111110, 1'b1);
        #1 check("eq_masked", eq, 1);
        tick();
        check_reg("reg_masked", 1, 1, 0, 0, 0, 0, 6'd0);
        mask = 32'h0;
`endif

        drive(32'h0, 32'h0, 1'b0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
